// File: rtl/pwm_deadtime_l1_if.sv
// Signal bundle between the PWM generator side and the dead-time stage.
// Widths of the dead-time fields follow DT_WIDTH and must match the stage's DT_WIDTH.
interface pwm_deadtime_l1_if #(
    parameter int unsigned DT_WIDTH = 16
);
    logic                ce;
    logic                enable;
    logic                pwm_in;
    logic [DT_WIDTH-1:0] dead_time_rise;
    logic [DT_WIDTH-1:0] dead_time_fall;
    logic                fault;
    logic                fault_clear;
    logic                hs_out;
    logic                ls_out;
    logic                fault_latched;
    logic [2:0]          state_o;

    modport master (
        output ce, enable, pwm_in, dead_time_rise, dead_time_fall, fault, fault_clear,
        input  hs_out, ls_out, fault_latched, state_o
    );

    modport slave (
        input  ce, enable, pwm_in, dead_time_rise, dead_time_fall, fault, fault_clear,
        output hs_out, ls_out, fault_latched, state_o
    );
endinterface

// File: rtl/pwm_deadtime_l1.sv
// Dead-time insertion: complementary high/low-side gate commands with both-off gaps.
// Optional FAULT_AUTORETRY_EN: sticky fault self-clears after RETRY_CYCLES fault-free cycles.
module pwm_deadtime_l1 #(
    parameter int unsigned DT_WIDTH     = 16,
    parameter int unsigned RETRY_CYCLES = 1000
) (
    input logic                aclk,
    input logic                resetn,
    pwm_deadtime_l1_if.slave   bus
);
    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_LS_ON   = 3'd1,
        S_DT_RISE = 3'd2,
        S_HS_ON   = 3'd3,
        S_DT_FALL = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DT_WIDTH-1:0] r_cnt;
    logic [DT_WIDTH-1:0] r_dt;
    logic                r_hs;
    logic                r_ls;
    logic                r_flt;
    logic                w_flt_next;
    logic                w_hs_next;
    logic                w_ls_next;
    logic                w_dt_done;
    logic                w_in_dt;
    logic                w_dt_entry;

    assign w_dt_done  = (r_cnt == r_dt);
    assign w_in_dt    = (r_state == S_DT_RISE) || (r_state == S_DT_FALL);
    assign w_dt_entry = ((w_next == S_DT_RISE) || (w_next == S_DT_FALL)) && (w_next != r_state);

    // A reversal of pwm_in inside a dead-time interval takes priority over completion,
    // so the switch that was about to turn on never does.
    always_comb begin
        w_next = r_state;
        if (bus.fault || r_flt || !bus.enable) begin
            w_next = S_OFF;
        end else begin
            case (r_state)
                S_OFF:     w_next = bus.pwm_in ? S_DT_RISE : S_DT_FALL;
                S_LS_ON:   if (bus.pwm_in) w_next = S_DT_RISE;
                S_DT_RISE: begin
                    if (!bus.pwm_in)    w_next = S_LS_ON;
                    else if (w_dt_done) w_next = S_HS_ON;
                end
                S_HS_ON:   if (!bus.pwm_in) w_next = S_DT_FALL;
                S_DT_FALL: begin
                    if (bus.pwm_in)     w_next = S_HS_ON;
                    else if (w_dt_done) w_next = S_LS_ON;
                end
                default:   w_next = S_OFF;
            endcase
        end
        w_hs_next = (w_next == S_HS_ON);
        w_ls_next = (w_next == S_LS_ON);
    end

`ifdef FAULT_AUTORETRY_EN
    localparam int unsigned RW = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
    logic [RW-1:0] r_retry;
    logic          w_retry_done;

    assign w_retry_done = r_flt && !bus.fault && (r_retry == RW'(RETRY_CYCLES - 1));

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_retry <= '0;
        end else if (!r_flt || bus.fault || w_retry_done) begin
            r_retry <= '0;
        end else begin
            r_retry <= r_retry + RW'(1);
        end
    end
`else
    logic w_retry_done;
    logic w_unused_retry;
    assign w_retry_done   = 1'b0;
    assign w_unused_retry = (RETRY_CYCLES == 0);
`endif

    always_comb begin
        w_flt_next = r_flt;
        if (bus.fault)            w_flt_next = 1'b1;
        else if (bus.fault_clear) w_flt_next = 1'b0;
        else if (w_retry_done)    w_flt_next = 1'b0;
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_OFF;
            r_hs    <= 1'b0;
            r_ls    <= 1'b0;
            r_flt   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hs    <= w_hs_next;
            r_ls    <= w_ls_next;
            r_flt   <= w_flt_next;
        end
    end

    // Dead time is captured on entry so mid-interval edits cannot stretch or cut it.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_dt  <= '0;
        end else if (w_dt_entry) begin
            r_cnt <= '0;
            r_dt  <= (w_next == S_DT_RISE) ? bus.dead_time_rise : bus.dead_time_fall;
        end else if (w_in_dt && bus.ce && !w_dt_done) begin
            r_cnt <= r_cnt + DT_WIDTH'(1);
        end
    end

    assign bus.hs_out        = r_hs;
    assign bus.ls_out        = r_ls;
    assign bus.fault_latched = r_flt;
    assign bus.state_o       = r_state;
endmodule

// File: tb/tb_pwm_deadtime_l1.sv
// Bench for pwm_deadtime_l1: directed vector table, multi-cycle corner sequences,
// then random stimulus against a behavioural model of the gate-drive rules.
module tb_pwm_deadtime_l1;
    localparam int unsigned DTW   = 16;
    localparam int unsigned RETRY = 20;

    logic aclk   = 1'b0;
    logic resetn = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    pwm_deadtime_l1_if #(.DT_WIDTH(DTW)) bus ();

    pwm_deadtime_l1 #(.DT_WIDTH(DTW), .RETRY_CYCLES(RETRY)) dut (
        .aclk   (aclk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    // Model: idle (both off), dead (both off, heading to m_side), on (m_side conducting).
    typedef enum int {M_IDLE, M_DEAD, M_ON} mmode_t;
    mmode_t      m_mode  = M_IDLE;
    bit          m_side  = 1'b0;
    int unsigned m_left  = 0;
    bit          m_flt   = 1'b0;
    int unsigned m_quiet = 0;

    typedef struct {
        bit             ce, en, pwm;
        logic [DTW-1:0] dtr, dtf;
        bit             f, fc;
        bit             hs, ls, flt;
        logic [2:0]     st;
    } vec_t;
    vec_t tbl[$];

    task automatic model_reset();
        m_mode = M_IDLE; m_side = 1'b0; m_left = 0; m_flt = 1'b0; m_quiet = 0;
    endtask

    task automatic model_step(input bit ce, input bit en, input bit pwm,
                              input logic [DTW-1:0] dtr, input logic [DTW-1:0] dtf,
                              input bit f, input bit fc);
        bit old_flt;
        old_flt = m_flt;
        if (f)       m_flt = 1'b1;
        else if (fc) m_flt = 1'b0;
`ifdef FAULT_AUTORETRY_EN
        if (f || !old_flt || fc) m_quiet = 0;
        else begin
            m_quiet++;
            if (m_quiet == RETRY) begin
                m_flt = 1'b0;
                m_quiet = 0;
            end
        end
`endif
        if (f || old_flt || !en) m_mode = M_IDLE;
        else begin
            case (m_mode)
                M_IDLE: begin
                    m_mode = M_DEAD; m_side = pwm; m_left = pwm ? dtr : dtf;
                end
                M_DEAD: begin
                    if (pwm != m_side)  begin m_mode = M_ON; m_side = pwm; end
                    else if (m_left == 0) m_mode = M_ON;
                    else if (ce)          m_left--;
                end
                default: begin
                    if (pwm != m_side) begin
                        m_mode = M_DEAD; m_side = pwm; m_left = pwm ? dtr : dtf;
                    end
                end
            endcase
        end
    endtask

    function automatic bit exp_hs(); return (m_mode == M_ON) && m_side;  endfunction
    function automatic bit exp_ls(); return (m_mode == M_ON) && !m_side; endfunction
    function automatic logic [2:0] exp_st();
        if (m_mode == M_IDLE) return 3'd0;
        if (m_mode == M_DEAD) return m_side ? 3'd2 : 3'd4;
        return m_side ? 3'd3 : 3'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input bit ce, input bit en, input bit pwm,
                        input logic [DTW-1:0] dtr, input logic [DTW-1:0] dtf,
                        input bit f, input bit fc);
        bus.ce = ce; bus.enable = en; bus.pwm_in = pwm;
        bus.dead_time_rise = dtr; bus.dead_time_fall = dtf;
        bus.fault = f; bus.fault_clear = fc;
        @(posedge aclk);
        model_step(ce, en, pwm, dtr, dtf, f, fc);
        @(negedge aclk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_hs"},  32'(bus.hs_out),        32'(exp_hs()));
        chk({tag, "_ls"},  32'(bus.ls_out),        32'(exp_ls()));
        chk({tag, "_flt"}, 32'(bus.fault_latched), 32'(m_flt));
        chk({tag, "_st"},  32'(bus.state_o),       32'(exp_st()));
        chk({tag, "_overlap"}, 32'(bus.hs_out & bus.ls_out), 32'd0);
    endtask

    task automatic add(input bit ce, input bit en, input bit pwm, input int dtr, input int dtf,
                       input bit f, input bit fc, input bit hs, input bit ls, input bit flt,
                       input int st);
        vec_t v;
        v.ce = ce; v.en = en; v.pwm = pwm; v.dtr = DTW'(dtr); v.dtf = DTW'(dtf);
        v.f = f; v.fc = fc; v.hs = hs; v.ls = ls; v.flt = flt; v.st = 3'(st);
        tbl.push_back(v);
    endtask

    initial begin
        int first_hs;
        bit rpwm;

        // ce en pwm dtr dtf f fc | hs ls flt st
        for (int i = 0; i < 6; i++) add(1,1,0, 3,5, 0,0, 0,0,0, 4);   // 6 both-off cycles
        add(1,1,0, 3,5, 0,0, 0,1,0, 1);
        add(1,1,0, 3,5, 0,0, 0,1,0, 1);
        for (int i = 0; i < 4; i++) add(1,1,1, 3,5, 0,0, 0,0,0, 2);   // rise, D=3
        add(1,1,1, 3,5, 0,0, 1,0,0, 3);
        add(1,1,1, 3,5, 0,0, 1,0,0, 3);
        add(1,1,1, 3,5, 1,0, 0,0,1, 0);                               // fault pulse in HS_ON
        add(1,1,1, 3,5, 0,0, 0,0,1, 0);
        add(1,1,1, 3,5, 0,0, 0,0,1, 0);
        add(1,1,1, 3,5, 0,1, 0,0,0, 0);                               // clear
        for (int i = 0; i < 4; i++) add(1,1,1, 3,5, 0,0, 0,0,0, 2);
        add(1,1,1, 3,5, 0,0, 1,0,0, 3);
        add(1,1,0, 3,5, 0,0, 0,0,0, 4);
        add(1,1,1, 3,5, 0,0, 1,0,0, 3);                               // abort back to HS_ON
        for (int i = 0; i < 6; i++) add(1,1,0, 3,5, 0,0, 0,0,0, 4);
        add(1,1,0, 3,5, 0,0, 0,1,0, 1);
        add(1,1,1, 10,5, 0,0, 0,0,0, 2);                              // 1-cycle glitch
        add(1,1,0, 10,5, 0,0, 0,1,0, 1);
        add(1,1,0, 10,5, 0,0, 0,1,0, 1);
        add(1,1,0, 3,5, 1,1, 0,0,1, 0);                               // fault beats clear
        add(1,1,0, 3,5, 0,0, 0,0,1, 0);
        add(1,1,0, 3,5, 0,1, 0,0,0, 0);
        add(1,1,0, 3,5, 0,0, 0,0,0, 4);
        add(1,0,0, 3,5, 0,0, 0,0,0, 0);                               // disable
        add(1,1,1, 0,5, 0,0, 0,0,0, 2);                               // dead time 0
        add(1,1,1, 0,5, 0,0, 1,0,0, 3);
        add(1,1,1, 7,5, 0,0, 1,0,0, 3);
        add(1,1,0, 7,2, 0,0, 0,0,0, 4);                               // latched D=2
        add(1,1,0, 7,9, 0,0, 0,0,0, 4);
        add(1,1,0, 7,9, 0,0, 0,0,0, 4);
        add(1,1,0, 7,9, 0,0, 0,1,0, 1);
        add(0,1,1, 1,5, 0,0, 0,0,0, 2);                               // ce gating
        add(0,1,1, 1,5, 0,0, 0,0,0, 2);
        add(0,1,1, 1,5, 0,0, 0,0,0, 2);
        add(1,1,1, 1,5, 0,0, 0,0,0, 2);
        add(0,1,1, 1,5, 0,0, 1,0,0, 3);

        bus.ce = 1'b0; bus.enable = 1'b0; bus.pwm_in = 1'b0;
        bus.dead_time_rise = '0; bus.dead_time_fall = '0;
        bus.fault = 1'b0; bus.fault_clear = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_hs",  32'(bus.hs_out),        32'd0);
        chk("rst_ls",  32'(bus.ls_out),        32'd0);
        chk("rst_flt", 32'(bus.fault_latched), 32'd0);
        chk("rst_st",  32'(bus.state_o),       32'd0);
        resetn = 1'b1;
        model_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ce, tbl[i].en, tbl[i].pwm, tbl[i].dtr, tbl[i].dtf, tbl[i].f, tbl[i].fc);
            chk($sformatf("vec%0d_hs", i),  32'(bus.hs_out),        32'(tbl[i].hs));
            chk($sformatf("vec%0d_ls", i),  32'(bus.ls_out),        32'(tbl[i].ls));
            chk($sformatf("vec%0d_flt", i), 32'(bus.fault_latched), 32'(tbl[i].flt));
            chk($sformatf("vec%0d_st", i),  32'(bus.state_o),       32'(tbl[i].st));
        end

        // ce every 4th cycle, D=2: hs expected on the 9th edge after the rise
        step(1,1,0, 2,0, 0,0);
        step(1,1,0, 2,0, 0,0);
        check_model("ce4_pre");
        first_hs = -1;
        for (int i = 0; i < 40 && first_hs < 0; i++) begin
            step((i % 4) == 3, 1, 1, 2, 0, 0, 0);
            check_model("ce4");
            if (bus.hs_out) first_hs = i;
        end
        chk("ce4_hs_edge", 32'(first_hs), 32'd8);

`ifdef FAULT_AUTORETRY_EN
        begin
            int clr_at;
            step(1,1,1, 2,2, 1,0);
            clr_at = -1;
            for (int i = 1; i <= 40 && clr_at < 0; i++) begin
                step(1,1,1, 2,2, 0,0);
                check_model("retry1");
                if (!bus.fault_latched) clr_at = i;
            end
            chk("retry1_len", 32'(clr_at), 32'(RETRY));
            step(1,1,1, 2,2, 1,0);
            for (int i = 1; i < 10; i++) step(1,1,1, 2,2, 0,0);
            step(1,1,1, 2,2, 1,0);
            check_model("retry2_refault");
            clr_at = -1;
            for (int i = 1; i <= 40 && clr_at < 0; i++) begin
                step(1,1,1, 2,2, 0,0);
                check_model("retry2");
                if (!bus.fault_latched) clr_at = i;
            end
            chk("retry2_len", 32'(clr_at), 32'(RETRY));
        end
`endif

        rpwm = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(11, 0) == 0) rpwm = ~rpwm;
            step($urandom_range(3, 0) != 0, $urandom_range(15, 0) != 0, rpwm,
                 DTW'($urandom_range(7, 0)), DTW'($urandom_range(7, 0)),
                 $urandom_range(63, 0) == 0, $urandom_range(15, 0) == 0);
            check_model("rand");
        end

        // asynchronous reset, observed before any clock edge
        #2 resetn = 1'b0;
        #1;
        chk("arst_hs",  32'(bus.hs_out),        32'd0);
        chk("arst_ls",  32'(bus.ls_out),        32'd0);
        chk("arst_flt", 32'(bus.fault_latched), 32'd0);
        chk("arst_st",  32'(bus.state_o),       32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
